// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the parametrised pipeline hazard unit:
//   - RV32I opcode constants used by the source/control decoder
//   - stall_cause encodings reported on the stall_cause output
//   - hazard FSM state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_LU   = 2'd1,
        CAUSE_CTRL = 2'd2,
        CAUSE_MEM  = 2'd3
    } stall_cause_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CTRL  = 2'd1,
        ST_MWAIT = 2'd2
    } haz_state_e;

endpackage

// File: rtl/hazard_src_decode.sv
// ----------------------------------------------------------------------------
// hazard_src_decode
// Combinational decode of the IF/ID instruction for hazard detection.
// Ports:
//   i_instr    in  32      instruction held in IF/ID
//   o_rs1      out REG_AW  rs1 field (instr[19:15])
//   o_rs2      out REG_AW  rs2 field (instr[24:20])
//   o_use_rs1  out 1       rs1 is a real source (not LUI/AUIPC/JAL)
//   o_use_rs2  out 1       rs2 is a real source (R-type, store, branch)
//   o_is_ctrl  out 1       instruction starts a control stall
// ----------------------------------------------------------------------------
module hazard_src_decode
    import hazard_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int STALL_ON_JUMP = 1
) (
    input  logic [31:0]       i_instr,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2,
    output logic              o_use_rs1,
    output logic              o_use_rs2,
    output logic              o_is_ctrl
);

    logic [6:0]  w_opcode;
    // Immediate/funct/rd bits play no part in hazard detection.
    logic [14:0] w_unused_fields;

    assign w_opcode        = i_instr[6:0];
    assign o_rs1           = REG_AW'(i_instr[19:15]);
    assign o_rs2           = REG_AW'(i_instr[24:20]);
    assign w_unused_fields = {i_instr[31:25], i_instr[14:7]};

    always_comb begin
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b0;
        o_is_ctrl = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: o_use_rs1 = 1'b0;
            OP_JAL: begin
                o_use_rs1 = 1'b0;
                o_is_ctrl = (STALL_ON_JUMP != 0);
            end
            OP_JALR:  o_is_ctrl = (STALL_ON_JUMP != 0);
            OP_BRANCH: begin
                o_use_rs2 = 1'b1;
                o_is_ctrl = 1'b1;
            end
            OP_RTYPE, OP_STORE: o_use_rs2 = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_unit_param.sv
// ----------------------------------------------------------------------------
// hazard_unit_param
// Pipeline stall unit beside the ID stage of the 5-stage RISC-V core.
// Generates PC / IF-ID write enables, the ID/EX bubble select and a
// whole-pipeline hold, and reports the stall cause plus a saturating
// count of stalled cycles.
//
// Optional build macro: HAZ_BR_EARLY_RELEASE_EN
//   defined   - br_resolved=1 in CTRL (mem_busy=0) ends the control stall
//               after the current (still stalled) cycle.
//   undefined - br_resolved is ignored; control stalls last BR_STALL_CYC.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   ifid_valid      IF/ID holds a real instruction
//   ifid_instr[31:0] instruction in IF/ID
//   idex_rd, idex_memread     destination / load flag in ID/EX
//   exmem_rd, exmem_memread   destination / load flag in EX/MEM (LU_DEPTH=2)
//   mem_busy        data memory not ready, freeze the whole pipeline
//   br_resolved     branch in EX resolved (early-release builds only)
//   pc_write, ifid_write      front-end enables
//   control_mux     1 = inject NOP control into ID/EX
//   pipe_hold       1 = hold ID/EX, EX/MEM and MEM/WB
//   stall_cause     0 none, 1 load-use, 2 control, 3 memory wait
//   stall_cnt       saturating count of stalled cycles
// ----------------------------------------------------------------------------
module hazard_unit_param
    import hazard_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int BR_STALL_CYC  = 2,
    parameter int STALL_ON_JUMP = 1,
    parameter int LU_DEPTH      = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifid_valid,
    input  logic [31:0]       ifid_instr,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_memread,
    input  logic              mem_busy,
    input  logic              br_resolved,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              control_mux,
    output logic              pipe_hold,
    output logic [1:0]        stall_cause,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_is_ctrl;
    logic              w_lu_idex;
    logic              w_lu_exmem;
    logic              w_lu;

    haz_state_e        r_state;
    haz_state_e        r_saved;
    haz_state_e        w_state_nxt;
    haz_state_e        w_saved_nxt;
    haz_state_e        w_eff_state;
    logic [2:0]        r_br_cnt;
    logic [2:0]        w_br_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_pc_write;
    logic              w_ifid_write;
    logic              w_control_mux;
    logic              w_pipe_hold;
    stall_cause_e      w_cause;

    hazard_src_decode #(
        .REG_AW        (REG_AW),
        .STALL_ON_JUMP (STALL_ON_JUMP)
    ) u_decode (
        .i_instr   (ifid_instr),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2),
        .o_is_ctrl (w_is_ctrl)
    );

    // x0 never carries a dependency, so rd==0 loads are not hazards.
    assign w_lu_idex  = idex_memread && (idex_rd != '0) &&
                        ((w_use_rs1 && (w_rs1 == idex_rd)) ||
                         (w_use_rs2 && (w_rs2 == idex_rd)));
    assign w_lu_exmem = exmem_memread && (exmem_rd != '0) &&
                        ((w_use_rs1 && (w_rs1 == exmem_rd)) ||
                         (w_use_rs2 && (w_rs2 == exmem_rd)));
    assign w_lu       = ifid_valid && (w_lu_idex || ((LU_DEPTH == 2) && w_lu_exmem));

`ifndef HAZ_BR_EARLY_RELEASE_EN
    logic w_unused_br_resolved;
    assign w_unused_br_resolved = br_resolved;
`endif

    // MWAIT is transparent: the cycle that ends a memory wait behaves as
    // the state that was interrupted.
    assign w_eff_state = (r_state == ST_MWAIT) ? r_saved : r_state;

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_control_mux = 1'b0;
        w_pipe_hold   = 1'b0;
        w_cause       = CAUSE_NONE;
        w_state_nxt   = w_eff_state;
        w_saved_nxt   = r_saved;
        w_br_cnt_nxt  = r_br_cnt;

        if (mem_busy) begin
            // Whole pipeline frozen; br_cnt holds its value.
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_hold  = 1'b1;
            w_cause      = CAUSE_MEM;
            w_state_nxt  = ST_MWAIT;
            w_saved_nxt  = w_eff_state;
        end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_control_mux = 1'b1;
            w_cause       = CAUSE_LU;
        end else if (r_br_cnt != 3'd0) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_control_mux = 1'b1;
            w_cause       = CAUSE_CTRL;
            w_br_cnt_nxt  = r_br_cnt - 3'd1;
            if (r_br_cnt == 3'd1) begin
                w_state_nxt = ST_RUN;
            end
        end else if ((w_eff_state == ST_RUN) && ifid_valid && w_is_ctrl) begin
            // Control instruction leaves ID this cycle; the bubbles land on
            // the instruction behind it.
            w_br_cnt_nxt = 3'(BR_STALL_CYC);
            w_state_nxt  = ST_CTRL;
        end

`ifdef HAZ_BR_EARLY_RELEASE_EN
        if (!mem_busy && (w_eff_state == ST_CTRL) && br_resolved) begin
            w_br_cnt_nxt = 3'd0;
            w_state_nxt  = ST_RUN;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_saved     <= ST_RUN;
            r_br_cnt    <= 3'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_saved  <= w_saved_nxt;
            r_br_cnt <= w_br_cnt_nxt;
            if ((w_cause != CAUSE_NONE) && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Reset forces a non-stalling front end regardless of the inputs.
    assign pc_write    = rst ? 1'b1 : w_pc_write;
    assign ifid_write  = rst ? 1'b1 : w_ifid_write;
    assign control_mux = rst ? 1'b0 : w_control_mux;
    assign pipe_hold   = rst ? 1'b0 : w_pipe_hold;
    assign stall_cause = rst ? 2'd0 : w_cause;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit_param.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit_param
// Directed scenarios followed by randomized traffic, every cycle compared
// against a bubble-count reference model of the stall rules.
// ----------------------------------------------------------------------------
module tb_hazard_unit_param;

    localparam int REG_AW = 5;
    localparam int BR     = 2;
    localparam int SOJ    = 1;
    localparam int LUD    = 1;
    localparam int CNTW   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ifid_valid = 1'b0;
    logic [31:0]       ifid_instr = 32'h0;
    logic [REG_AW-1:0] idex_rd = '0;
    logic              idex_memread = 1'b0;
    logic [REG_AW-1:0] exmem_rd = '0;
    logic              exmem_memread = 1'b0;
    logic              mem_busy = 1'b0;
    logic              br_resolved = 1'b0;
    logic              pc_write;
    logic              ifid_write;
    logic              control_mux;
    logic              pipe_hold;
    logic [1:0]        stall_cause;
    logic [CNTW-1:0]   stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_bub = 0;
    int m_cnt = 0;

    hazard_unit_param #(
        .REG_AW        (REG_AW),
        .BR_STALL_CYC  (BR),
        .STALL_ON_JUMP (SOJ),
        .LU_DEPTH      (LUD),
        .CNT_W         (CNTW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .idex_rd       (idex_rd),
        .idex_memread  (idex_memread),
        .exmem_rd      (exmem_rd),
        .exmem_memread (exmem_memread),
        .mem_busy      (mem_busy),
        .br_resolved   (br_resolved),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .control_mux   (control_mux),
        .pipe_hold     (pipe_hold),
        .stall_cause   (stall_cause),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    endfunction

    function automatic bit starts_ctrl(input logic [6:0] op);
        if (op == 7'b1100011) return 1'b1;
        return (SOJ != 0) && (op == 7'b1101111 || op == 7'b1100111);
    endfunction

    function automatic bit dep_on(input logic [31:0] ins, input logic [4:0] rd, input logic ld);
        if (!ld || rd == 5'd0) return 1'b0;
        return (reads_rs1(ins[6:0]) && ins[19:15] == rd) ||
               (reads_rs2(ins[6:0]) && ins[24:20] == rd);
    endfunction

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic step(input logic r, input logic v, input logic [31:0] ins,
                        input logic [4:0] xrd, input logic xld,
                        input logic [4:0] mrd, input logic mld,
                        input logic mb, input logic brr);
        int  cause;
        int  nxt_bub;
        bit  lu;
        @(negedge clk);
        rst = r; ifid_valid = v; ifid_instr = ins;
        idex_rd = xrd; idex_memread = xld; exmem_rd = mrd; exmem_memread = mld;
        mem_busy = mb; br_resolved = brr;
        #1;
        if (r) begin
            m_bub = 0;
            m_cnt = 0;
        end
        lu = v && (dep_on(ins, xrd, xld) || (LUD == 2 && dep_on(ins, mrd, mld)));
        nxt_bub = m_bub;
        cause = 0;
        if (r) cause = 0;
        else if (mb) cause = 3;
        else if (lu) cause = 1;
        else if (m_bub > 0) begin
            cause = 2;
            nxt_bub = m_bub - 1;
        end else if (v && starts_ctrl(ins[6:0])) nxt_bub = BR;
`ifdef HAZ_BR_EARLY_RELEASE_EN
        if (!r && !mb && m_bub > 0 && brr) nxt_bub = 0;
`endif
        check("pc_write",    {31'd0, pc_write},    (cause == 0) ? 32'd1 : 32'd0);
        check("ifid_write",  {31'd0, ifid_write},  (cause == 0) ? 32'd1 : 32'd0);
        check("control_mux", {31'd0, control_mux}, (cause == 1 || cause == 2) ? 32'd1 : 32'd0);
        check("pipe_hold",   {31'd0, pipe_hold},   (cause == 3) ? 32'd1 : 32'd0);
        check("stall_cause", {30'd0, stall_cause}, cause);
        check("stall_cnt",   {16'd0, stall_cnt},   m_cnt);
        @(posedge clk);
        if (!r) begin
            m_bub = nxt_bub;
            if (cause != 0 && m_cnt < (1 << CNTW) - 1) m_cnt++;
        end
    endtask

    localparam logic [31:0] I_NOP  = {12'd0, 5'd0, 3'd0, 5'd0, 7'b0010011};
    localparam logic [31:0] I_ADD  = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] I_ADDI = {12'd7, 5'd5, 3'd0, 5'd6, 7'b0010011};
    localparam logic [31:0] I_BEQ  = {7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'b1100011};

    task automatic idle(input logic [31:0] ins);
        step(1'b0, 1'b1, ins, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [6:0] ops [10];

    initial begin
        ops = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
                7'b0110011, 7'b0100011, 7'b0000011, 7'b0010011, 7'b1110011};

        // reset with hazard-provoking inputs: outputs must stay non-stalling
        step(1'b1, 1'b1, I_ADD, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        do_reset();

        // load-use on rs1, then release once the bubble is in ID/EX
        step(1'b0, 1'b1, I_ADD, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(I_ADD);
        check("lu_total", {16'd0, stall_cnt}, 32'd1);

        // rs2 field equals load rd, but addi has no rs2 source
        do_reset();
        step(1'b0, 1'b1, I_ADDI, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        // EX/MEM load ignored at depth 1
        step(1'b0, 1'b1, I_ADD, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        check("rs2_filter_total", {16'd0, stall_cnt}, 32'd0);

        // branch: trigger cycle free, then BR bubbles
        do_reset();
        idle(I_BEQ);
        for (int i = 0; i < BR + 2; i++) idle(I_NOP);
        check("br_total", {16'd0, stall_cnt}, BR);

        // memory wait after first branch bubble
        do_reset();
        idle(I_BEQ);
        idle(I_NOP);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(I_NOP);
        check("br_mem_total", {16'd0, stall_cnt}, 32'd5);

        // early release in first CTRL cycle
        do_reset();
        idle(I_BEQ);
        step(1'b0, 1'b1, I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(I_NOP);
`ifdef HAZ_BR_EARLY_RELEASE_EN
        check("early_rel_total", {16'd0, stall_cnt}, 32'd1);
`else
        check("early_rel_total", {16'd0, stall_cnt}, BR);
`endif

        // reset during CTRL: immediate non-stall, no residual bubbles
        do_reset();
        idle(I_BEQ);
        step(1'b1, 1'b1, I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(I_NOP);
        check("rst_ctrl_total", {16'd0, stall_cnt}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom();
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 9) < 8),
                 ins,
                 5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 9) < 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
